// File: rtl/ising_config_pkg.sv
// Shared constants for GPIO-configured Ising signal-chain stages: lane geometry,
// GPIO bus field positions and the default register map.
package ising_config;

  localparam int NUM_LANES  = 16;
  localparam int LANE_W     = 16;
  localparam int DAC_WORD_W = 256;

  localparam int GPIO_ADDR_LSB = 0;
  localparam int GPIO_DATA_LSB = 16;
  localparam int GPIO_WCLK_BIT = 24;

  localparam logic [15:0] DEF_ADDR_START  = 16'd5;
  localparam logic [15:0] DEF_ADDR_LEN    = 16'd6;
  localparam logic [15:0] DEF_ADDR_PER_LO = 16'd7;
  localparam logic [15:0] DEF_ADDR_PER_HI = 16'd8;
  localparam logic [15:0] DEF_ADDR_CTRL   = 16'd9;

  localparam logic [3:0]  RST_START = 4'd7;
  localparam logic [4:0]  RST_LEN   = 5'd8;
  localparam logic [15:0] RST_PER   = 16'd1;

  // Lanes start..start+len-1, clipped at the top lane; the window never wraps.
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [3:0] start,
                                                     input logic [4:0] len);
    logic [NUM_LANES-1:0] mask;
    logic [5:0] lo;
    logic [5:0] hi;
    lo   = {2'b00, start};
    hi   = lo + ((len > 5'd16) ? 6'd16 : {1'b0, len});
    mask = '0;
    for (int k = 0; k < NUM_LANES; k++)
      mask[k] = (6'(k) >= lo) && (6'(k) < hi);
    return mask;
  endfunction

endpackage

// File: rtl/dac_pulse_former_if.sv
// Amplitude stream in, DAC sample words out. The master side is the upstream
// source/observer; the slave side is the pulse former itself.
interface dac_pulse_former_if;
  import ising_config::*;

  logic [LANE_W-1:0]     amp_in;
  logic                  amp_in_valid;
  logic                  amp_in_ready;
  logic [DAC_WORD_W-1:0] fsm_val_out;
  logic                  fsm_out_valid;
  logic                  sym_strobe;

  modport master (output amp_in, amp_in_valid,
                  input  amp_in_ready, fsm_val_out, fsm_out_valid, sym_strobe);
  modport slave  (input  amp_in, amp_in_valid,
                  output amp_in_ready, fsm_val_out, fsm_out_valid, sym_strobe);
endinterface

// File: rtl/gpio_reg_write.sv
// GPIO write front end: synchronises the w_clk strobe and emits a single-cycle
// wr_en on its rising edge, with address/data taken straight from the bus.
module gpio_reg_write
  import ising_config::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_in,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data
);

  logic [2:0] wclk_sync;
  logic       unused_gpio_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wclk_sync <= '0;
    else      wclk_sync <= {wclk_sync[1:0], gpio_in[GPIO_WCLK_BIT]};
  end

  // Address/data are held stable by the bus master while the strobe is high.
  assign wr_en          = wclk_sync[1] & ~wclk_sync[2];
  assign wr_addr        = gpio_in[GPIO_ADDR_LSB +: 16];
  assign wr_data        = gpio_in[GPIO_DATA_LSB +: 8];
  assign unused_gpio_hi = ^gpio_in[31:25];

endmodule

// File: rtl/dac_pulse_former.sv
// Turns an amplitude stream into 16-lane DAC words: one windowed pulse word per
// symbol period followed by zero gap words; shape/timing set over GPIO.
module dac_pulse_former
  import ising_config::*;
#(
  parameter logic [15:0] ADDR_START  = DEF_ADDR_START,
  parameter logic [15:0] ADDR_LEN    = DEF_ADDR_LEN,
  parameter logic [15:0] ADDR_PER_LO = DEF_ADDR_PER_LO,
  parameter logic [15:0] ADDR_PER_HI = DEF_ADDR_PER_HI,
  parameter logic [15:0] ADDR_CTRL   = DEF_ADDR_CTRL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         gpio_in,
  dac_pulse_former_if.slave   pf,
  output logic [15:0]         underrun_cnt
);

  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  logic [3:0]  start_r, sh_start, sym_start;
  logic [4:0]  len_r, sh_len, sym_len;
  logic [7:0]  per_lo, per_hi;
  logic [15:0] sh_per, peff, sym_per;
  logic [15:0] cnt;
  logic        en_r, slot, xfer, clr;
  logic [NUM_LANES-1:0]  mask;
  logic [DAC_WORD_W-1:0] pulse_word;

  gpio_reg_write u_gpio (
    .clk     (clk),
    .rst     (rst),
    .gpio_in (gpio_in),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  assign clr = wr_en && (wr_addr == ADDR_CTRL) && wr_data[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_r <= RST_START;
      len_r   <= RST_LEN;
      per_lo  <= RST_PER[7:0];
      per_hi  <= RST_PER[15:8];
      en_r    <= 1'b0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_START:  start_r <= wr_data[3:0];
        ADDR_LEN:    len_r   <= wr_data[4:0];
        ADDR_PER_LO: per_lo  <= wr_data;
        ADDR_PER_HI: per_hi  <= wr_data;
        ADDR_CTRL:   en_r    <= wr_data[0];
        default: ;
      endcase
    end
  end

  // On the slot cycle the live registers are the ones being latched into the
  // shadows, so the pulse and the wrap point already use the new symbol's values.
  always_comb begin
    peff      = ({per_hi, per_lo} == 16'd0) ? 16'd1 : {per_hi, per_lo};
    slot      = en_r && (cnt == 16'd0);
    xfer      = slot && pf.amp_in_valid;
    sym_per   = (cnt == 16'd0) ? peff    : sh_per;
    sym_start = (cnt == 16'd0) ? start_r : sh_start;
    sym_len   = (cnt == 16'd0) ? len_r   : sh_len;
    mask      = lane_mask(sym_start, sym_len);
    pulse_word = '0;
    for (int k = 0; k < NUM_LANES; k++)
      if (xfer && mask[k]) pulse_word[k*LANE_W +: LANE_W] = pf.amp_in;
  end

  assign pf.amp_in_ready = slot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      sh_start <= RST_START;
      sh_len   <= RST_LEN;
      sh_per   <= RST_PER;
    end else begin
      if (!en_r)                         cnt <= '0;
      else if (cnt == sym_per - 16'd1)   cnt <= '0;
      else                               cnt <= cnt + 16'd1;
      if (slot) begin
        sh_start <= start_r;
        sh_len   <= len_r;
        sh_per   <= peff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pf.fsm_val_out   <= '0;
      pf.fsm_out_valid <= 1'b0;
      pf.sym_strobe    <= 1'b0;
      underrun_cnt     <= '0;
    end else begin
      pf.fsm_val_out   <= pulse_word;
      pf.fsm_out_valid <= en_r;
      pf.sym_strobe    <= slot;
      // A clear landing together with an underrun slot leaves the count at zero.
      if (clr)
        underrun_cnt <= '0;
      else if (slot && !pf.amp_in_valid && (underrun_cnt != 16'hFFFF))
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dac_pulse_former.sv
// Directed bench for dac_pulse_former: a cycle model pushes expected words to a
// queue on each pulse slot and pops them against the DUT one cycle later.
module tb_dac_pulse_former;
  import ising_config::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio_in;
  logic [15:0] underrun_cnt;

  dac_pulse_former_if pf ();

  dac_pulse_former dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_in      (gpio_in),
    .pf           (pf),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int          m_start, m_len;
  logic [15:0] m_per, m_psh, m_cnt, m_under;
  logic        m_en, e_valid, e_strobe, last_xfer;
  logic [255:0] exp_q[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic logic [255:0] pulse(input logic [15:0] a, input int s, input int l);
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < 16; k++)
      if (k >= s && k < s + l) w[16*k +: 16] = a;
    return w;
  endfunction

  task automatic model_reset();
    m_start = 7; m_len = 8; m_per = 16'd1; m_psh = 16'd1; m_cnt = '0;
    m_under = '0; m_en = 1'b0; e_valid = 1'b0; e_strobe = 1'b0; last_xfer = 1'b0;
    exp_q.delete();
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    logic [255:0] ew;
    logic         slot;
    @(negedge clk);
    if (rst) begin
      ew = '0;
      if (e_strobe) begin
        chk("sb_nonempty", 256'(exp_q.size() > 0), 256'd1);
        if (exp_q.size() > 0) ew = exp_q.pop_front();
      end
      chk("out_valid",  pf.fsm_out_valid, e_valid);
      chk("sym_strobe", pf.sym_strobe, e_strobe);
      chk("word",       pf.fsm_val_out, ew);
      chk("underrun",   underrun_cnt, m_under);
      slot = m_en && (m_cnt == 16'd0);
      chk("ready",      pf.amp_in_ready, slot);
      e_valid   = m_en;
      e_strobe  = slot;
      last_xfer = slot && pf.amp_in_valid;
      if (slot) begin
        m_psh = (m_per == 16'd0) ? 16'd1 : m_per;
        exp_q.push_back(last_xfer ? pulse(pf.amp_in, m_start, m_len) : 256'd0);
        if (!last_xfer && m_under != 16'hFFFF) m_under = m_under + 16'd1;
      end
      if (!m_en) m_cnt = '0;
      else       m_cnt = (m_cnt == m_psh - 16'd1) ? 16'd0 : m_cnt + 16'd1;
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
  endtask

  // The write lands on the third rising edge after the strobe goes high.
  task automatic gpio_wr(input logic [15:0] a, input logic [7:0] d, input int hold);
    gpio_in = {7'd0, 1'b1, d, a};
    repeat (3) tick();
    case (a)
      16'd5: m_start = int'(d[3:0]);
      16'd6: m_len   = int'(d[4:0]);
      16'd7: m_per[7:0]  = d;
      16'd8: m_per[15:8] = d;
      16'd9: begin
        m_en = d[0];
        if (d[1]) m_under = '0;
      end
      default: ;
    endcase
    repeat (hold - 3) tick();
    gpio_in = 32'd0;
    repeat (3) tick();
  endtask

  task automatic send_amp(input logic [15:0] a);
    bit done;
    done = 1'b0;
    pf.amp_in = a;
    pf.amp_in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = last_xfer;
    end
    chk("send_accepted", 256'(done), 256'd1);
  endtask

  initial begin
    rst = 1'b0;
    gpio_in = 32'd0;
    pf.amp_in = '0;
    pf.amp_in_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",    pf.fsm_out_valid, 1'b0);
    chk("rst_strobe",   pf.sym_strobe, 1'b0);
    chk("rst_word",     pf.fsm_val_out, 256'd0);
    chk("rst_ready",    pf.amp_in_ready, 1'b0);
    chk("rst_underrun", underrun_cnt, 16'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Defaults, back-to-back pulses of a constant amplitude.
    pf.amp_in = 16'h1234;
    pf.amp_in_valid = 1'b1;
    gpio_wr(16'd9, 8'h01, 4);
    repeat (8) tick();

    // Period 4 with a changing amplitude.
    gpio_wr(16'd9, 8'h00, 3);
    gpio_wr(16'd7, 8'd4, 3);
    gpio_wr(16'd9, 8'h01, 3);
    send_amp(16'd1);
    send_amp(16'd2);
    send_amp(16'd3);
    repeat (3) tick();

    // Window clipping, empty window, oversize length.
    gpio_wr(16'd9, 8'h00, 3);
    gpio_wr(16'd5, 8'd12, 3);
    gpio_wr(16'd6, 8'd8, 3);
    gpio_wr(16'd9, 8'h01, 3);
    send_amp(16'h5555);
    gpio_wr(16'd6, 8'd0, 3);
    send_amp(16'h7777);
    gpio_wr(16'd6, 8'd20, 3);
    gpio_wr(16'd5, 8'd0, 3);
    send_amp(16'h1111);
    repeat (4) tick();

    // Underruns at period 2, then clear with enable kept on.
    gpio_wr(16'd9, 8'h00, 3);
    gpio_wr(16'd5, 8'd7, 3);
    gpio_wr(16'd6, 8'd8, 3);
    gpio_wr(16'd7, 8'd2, 3);
    gpio_wr(16'd9, 8'h01, 3);
    send_amp(16'h2222);
    pf.amp_in_valid = 1'b0;
    repeat (6) tick();
    chk("underrun_three", underrun_cnt, 16'd3);
    pf.amp_in_valid = 1'b1;
    gpio_wr(16'd9, 8'h03, 4);
    chk("underrun_cleared", underrun_cnt, 16'd0);
    chk("en_kept", pf.fsm_out_valid, 1'b1);

    // Mid-symbol start change at period 10.
    gpio_wr(16'd9, 8'h00, 3);
    gpio_wr(16'd7, 8'd10, 3);
    gpio_wr(16'd9, 8'h01, 3);
    send_amp(16'h0ABC);
    repeat (4) tick();
    gpio_wr(16'd5, 8'd0, 3);
    send_amp(16'h0DEF);
    send_amp(16'h0FED);
    repeat (3) tick();

    // Asynchronous reset mid-period.
    #2 rst = 1'b0;
    #1;
    chk("arst_valid",    pf.fsm_out_valid, 1'b0);
    chk("arst_strobe",   pf.sym_strobe, 1'b0);
    chk("arst_word",     pf.fsm_val_out, 256'd0);
    chk("arst_ready",    pf.amp_in_ready, 1'b0);
    chk("arst_underrun", underrun_cnt, 16'd0);
    model_reset();
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // Defaults restored; a 20-cycle w_clk pulse must clear exactly once.
    pf.amp_in = 16'hBEEF;
    pf.amp_in_valid = 1'b1;
    gpio_wr(16'd9, 8'h01, 4);
    repeat (4) tick();
    pf.amp_in_valid = 1'b0;
    repeat (5) tick();
    gpio_wr(16'd9, 8'h03, 20);
    repeat (5) tick();
    chk("underrun_after_hold", underrun_cnt, m_under);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
